regfile_read_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit 16:1 register-read multiplexer between several requesters, such as fetch/decode, execute and debug readers. It accepts register-read requests, selects one winner per access, drives the multiplexer's 4-bit select lines, and captures the multiplexer output into a registered read-data port. It sits between the requesting pipeline units and the register-file read mux of the simple processor.

---
 rtl/regfile_read_arbiter_if.sv | 28 ++
 rtl/regfile_read_arbiter.sv | 92 +++++++++
 tb/tb_regfile_read_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Bus between the requesting pipeline units, the shared 16:1 register-read
// mux and the read arbiter. The arbiter side uses the slave modport; the
// requester/mux side uses the master modport.
interface regfile_read_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_sel;
  logic [3:0]        mux_sel;
  logic [DATA_W-1:0] mux_data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [ID_W-1:0]   rid;

  modport slave (
    input  req, req_sel, mux_data,
    output mux_sel, gnt, busy, rdata, rvalid, rid
  );

  modport master (
    output req, req_sel, mux_data,
    input  mux_sel, gnt, busy, rdata, rvalid, rid
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter/sequencer for one shared 16:1 register-read mux.
// Each access takes two cycles: a grant cycle in which mux_sel is driven and
// the mux settles, then a capture edge that registers mux_data into rdata.
module regfile_read_arbiter #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset,
  regfile_read_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [ID_W-1:0] last;   // previous winner; search starts just after it
  logic [ID_W-1:0] owner;  // requester whose access is in flight

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [3:0]      win_sel;
  logic [ID_W-1:0] idx;

  // Round-robin search: first set req bit starting at (last+1) mod NREQ.
  // NOTE: every variable driven here gets a default first, otherwise a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ID_W'((int'(last) + i) % NREQ);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Register index requested by the current winner.
  always_comb begin
    win_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_id == ID_W'(k)) win_sel = bus.req_sel[4*k +: 4];
    end
  end

  // Access sequencer: grant in IDLE, capture mux output in BUSY.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= ID_W'(NREQ - 1);
      owner      <= '0;
      bus.mux_sel <= '0;
      bus.gnt    <= '0;
      bus.busy   <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.rid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.rvalid <= 1'b0;
          if (win_found) begin
            bus.mux_sel <= win_sel;
            owner       <= win_id;
            bus.gnt     <= NREQ'(1) << win_id;
            bus.busy    <= 1'b1;
            state       <= BUSY;
          end else begin
            // mux_sel deliberately holds its last value between accesses.
            bus.gnt <= '0;
          end
        end
        BUSY: begin
          bus.rdata  <= bus.mux_data;
          bus.rid    <= owner;
          bus.rvalid <= 1'b1;
          last       <= owner;
          bus.gnt    <= '0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: models the 16:1 register mux with
// a small register table and checks grant order, timing and captured data.
module tb_regfile_read_arbiter;
  localparam int NREQ   = 4;
  localparam int ID_W   = 2;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] regs [16];

  regfile_read_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  regfile_read_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Combinational register-file read mux.
  assign bus.mux_data = regs[bus.mux_sel];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    bus.req     = '0;
    bus.req_sel = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({bus.gnt, bus.busy, bus.rvalid, bus.rid, bus.rdata, bus.mux_sel} !== '0) begin
      errors++;
      $display("FAIL reset_values gnt=%b busy=%b rvalid=%b rid=%0d rdata=%h mux_sel=%h, all must be 0",
               bus.gnt, bus.busy, bus.rvalid, bus.rid, bus.rdata, bus.mux_sel);
    end
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.busy, bus.rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL idle_no_req gnt=%b busy=%b rvalid=%b, required 0/0/0", bus.gnt, bus.busy, bus.rvalid);
    end
  endtask

  task automatic test_single;
    do_reset();
    bus.req_sel = {4'h0, 4'h0, 4'hF, 4'h0};
    bus.req     = 4'b0010;
    tick();
    checks++;
    if ({bus.gnt, bus.busy, bus.mux_sel, bus.rvalid} !== {4'b0010, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL single_grant gnt=%b busy=%b mux_sel=%h rvalid=%b, required 0010/1/f/0",
               bus.gnt, bus.busy, bus.mux_sel, bus.rvalid);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.rvalid, bus.rdata, bus.rid, bus.busy, bus.gnt} !== {1'b1, 32'hDEADBEEF, 2'd1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL single_capture rvalid=%b rdata=%h rid=%0d busy=%b gnt=%b, required 1/deadbeef/1/0/0000",
               bus.rvalid, bus.rdata, bus.rid, bus.busy, bus.gnt);
    end
    tick();
    checks++;
    if ({bus.rvalid, bus.mux_sel} !== {1'b0, 4'hF}) begin
      errors++;
      $display("FAIL single_after rvalid=%b mux_sel=%h, required 0/f", bus.rvalid, bus.mux_sel);
    end
  endtask

  task automatic test_all_four;
    logic [3:0] sel [NREQ];
    sel[0] = 4'h2; sel[1] = 4'h5; sel[2] = 4'h9; sel[3] = 4'hC;
    do_reset();
    bus.req_sel = {sel[3], sel[2], sel[1], sel[0]};
    bus.req     = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.mux_sel, bus.busy} !== {4'(1 << k), sel[k], 1'b1}) begin
        errors++;
        $display("FAIL all4_grant%0d gnt=%b mux_sel=%h busy=%b, required %b/%h/1",
                 k, bus.gnt, bus.mux_sel, bus.busy, 4'(1 << k), sel[k]);
      end
      bus.req[k] = 1'b0;
      tick();
      checks++;
      if ({bus.rvalid, bus.rid, bus.rdata, bus.gnt} !== {1'b1, 2'(k), regs[sel[k]], 4'b0000}) begin
        errors++;
        $display("FAIL all4_data%0d rvalid=%b rid=%0d rdata=%h gnt=%b, required 1/%0d/%h/0000",
                 k, bus.rvalid, bus.rid, bus.rdata, bus.gnt, k, regs[sel[k]]);
      end
    end
  endtask

  task automatic test_fairness;
    do_reset();
    bus.req_sel = {4'hA, 4'h1, 4'h0, 4'h4};
    bus.req     = 4'b0100;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL fair_first gnt=%b, required 0100", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1001;
    tick();
    checks++;
    if ({bus.gnt, bus.mux_sel} !== {4'b1000, 4'hA}) begin
      errors++;
      $display("FAIL fair_3_before_0 gnt=%b mux_sel=%h, required 1000/a", bus.gnt, bus.mux_sel);
    end
    bus.req = 4'b0001;
    tick();
    checks++;
    if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd3, regs[4'hA]}) begin
      errors++;
      $display("FAIL fair_data3 rvalid=%b rid=%0d rdata=%h, required 1/3/%h", bus.rvalid, bus.rid, bus.rdata, regs[4'hA]);
    end
    tick();
    checks++;
    if ({bus.gnt, bus.mux_sel} !== {4'b0001, 4'h4}) begin
      errors++;
      $display("FAIL fair_wrap_to_0 gnt=%b mux_sel=%h, required 0001/4", bus.gnt, bus.mux_sel);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_late_drop;
    do_reset();
    bus.req_sel = {4'h0, 4'h0, 4'h5, 4'h3};
    bus.req     = 4'b0011;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL late_first gnt=%b, required 0001", bus.gnt);
    end
    tick();  // requester 0 still high through the capture cycle
    tick();
    checks++;
    if ({bus.gnt, bus.mux_sel} !== {4'b0010, 4'h5}) begin
      errors++;
      $display("FAIL late_1_before_0 gnt=%b mux_sel=%h, required 0010/5", bus.gnt, bus.mux_sel);
    end
    bus.req = 4'b0001;
    tick();
    checks++;
    if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd1, regs[5]}) begin
      errors++;
      $display("FAIL late_data1 rvalid=%b rid=%0d rdata=%h, required 1/1/%h", bus.rvalid, bus.rid, bus.rdata, regs[5]);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL late_second0 gnt=%b, required 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 2'd0, regs[3]}) begin
      errors++;
      $display("FAIL late_data0 rvalid=%b rid=%0d rdata=%h, required 1/0/%h", bus.rvalid, bus.rid, bus.rdata, regs[3]);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.req_sel = {4'h8, 4'h6, 4'h0, 4'h1};
    bus.req     = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();   // access to 2 completes: rdata nonzero, last=2
    bus.req = 4'b1000;
    tick();
    checks++;
    if ({bus.gnt, bus.busy} !== {4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL rmid_grant3 gnt=%b busy=%b, required 1000/1", bus.gnt, bus.busy);
    end
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.gnt, bus.busy, bus.rvalid, bus.rid, bus.rdata, bus.mux_sel} !== '0) begin
      errors++;
      $display("FAIL rmid_outputs gnt=%b busy=%b rvalid=%b rid=%0d rdata=%h mux_sel=%h, all must be 0",
               bus.gnt, bus.busy, bus.rvalid, bus.rid, bus.rdata, bus.mux_sel);
    end
    reset   = 1'b0;
    bus.req = 4'b1001;
    tick();
    checks++;
    if ({bus.gnt, bus.rvalid, bus.mux_sel} !== {4'b0001, 1'b0, 4'h1}) begin
      errors++;
      $display("FAIL rmid_next0 gnt=%b rvalid=%b mux_sel=%h, required 0001/0/1", bus.gnt, bus.rvalid, bus.mux_sel);
    end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_sel_change;
    do_reset();
    bus.req_sel = {4'h0, 4'h0, 4'h0, 4'h3};
    bus.req     = 4'b0001;
    tick();
    bus.req_sel[3:0] = 4'h7;
    bus.req          = 4'b0000;
    checks++;
    if ({bus.gnt, bus.mux_sel} !== {4'b0001, 4'h3}) begin
      errors++;
      $display("FAIL selchg_grant gnt=%b mux_sel=%h, required 0001/3", bus.gnt, bus.mux_sel);
    end
    tick();
    checks++;
    if ({bus.rvalid, bus.rdata, bus.mux_sel} !== {1'b1, 32'h3333_3333, 4'h3}) begin
      errors++;
      $display("FAIL selchg_capture rvalid=%b rdata=%h mux_sel=%h, required 1/33333333/3",
               bus.rvalid, bus.rdata, bus.mux_sel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE_0000 | 32'(i);
    regs[3]  = 32'h3333_3333;
    regs[7]  = 32'h7777_7777;
    regs[15] = 32'hDEAD_BEEF;
    reset       = 1'b1;
    bus.req     = '0;
    bus.req_sel = '0;

    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_late_drop();
    test_reset_mid();
    test_sel_change();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
